// File: rtl/siggen_pkg.sv
// Shared types and helpers for the waveform capture write path.
package siggen_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } capture_state_t;

    // Samples still owed after the trigger sample itself: DEPTH - pre_count - 1, mod DEPTH.
    function automatic logic [31:0] post_trigger_len(input int unsigned addr_width,
                                                      input logic [31:0] pre_count);
        logic [31:0] depth;
        depth = 32'd1 << addr_width;
        return (depth - pre_count - 32'd1) & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/capture_writer_if.sv
// Sample stream plus RAM write port of the capture writer.
interface capture_writer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output s_valid, s_data,
        input  s_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/addr_counter.sv
// Wrap-around address counter with synchronous clear and count enable.
module addr_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Counter register; wraps naturally from all-ones to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (en) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/capture_writer.sv
// Write-side controller for the circular waveform capture RAM: pre-trigger
// history, rising level-crossing trigger, post-trigger fill.
module capture_writer
    import siggen_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic [ADDR_WIDTH-1:0] pre_count,
    input  logic [DATA_WIDTH-1:0] trig_level,
    capture_writer_if.slave       bus,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    capture_state_t        state_r;
    capture_state_t        next_state_s;
    logic [ADDR_WIDTH-1:0] wptr_s;
    logic [ADDR_WIDTH-1:0] fill_r;
    logic [ADDR_WIDTH-1:0] remaining_r;
    logic [ADDR_WIDTH-1:0] pre_r;
    logic [ADDR_WIDTH-1:0] post_len_s;
    logic [ADDR_WIDTH-1:0] trig_addr_r;
    logic [DATA_WIDTH-1:0] prev_r;
    logic                  prev_valid_r;
    logic                  s_ready_s;
    logic                  arm_take_s;
    logic                  accept_s;
    logic                  trig_s;
    logic                  wr_en_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;

    // Stream readiness and arm qualification decoded from the current state
    always_comb begin
        s_ready_s  = 1'b0;
        arm_take_s = 1'b0;
        case (state_r)
            PRE, WAIT, POST: s_ready_s  = 1'b1;
            IDLE, DONE:      arm_take_s = arm;
            default: begin
                s_ready_s  = 1'b0;
                arm_take_s = 1'b0;
            end
        endcase
    end

    assign accept_s   = bus.s_valid & s_ready_s;
    assign trig_s     = (state_r == WAIT) & accept_s & prev_valid_r &
                        (prev_r < trig_level) & (bus.s_data >= trig_level);
    assign post_len_s = ADDR_WIDTH'(post_trigger_len(ADDR_WIDTH, 32'(pre_r)));

    addr_counter #(.WIDTH(ADDR_WIDTH)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (arm_take_s),
        .en    (accept_s),
        .count (wptr_s)
    );

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (arm_take_s) begin
                    next_state_s = (pre_count == ADDR_ZERO) ? WAIT : PRE;
                end else begin
                    next_state_s = state_r;
                end
            end
            PRE: begin
                if (accept_s && ((fill_r + ADDR_ONE) == pre_r)) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = PRE;
                end
            end
            WAIT: begin
                if (trig_s) begin
                    next_state_s = (post_len_s == ADDR_ZERO) ? DONE : POST;
                end else begin
                    next_state_s = WAIT;
                end
            end
            POST: begin
                if (accept_s && (remaining_r == ADDR_ONE)) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = POST;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture bookkeeping: pre-trigger fill, post-trigger countdown, trigger history
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r        <= ADDR_ZERO;
            fill_r       <= ADDR_ZERO;
            remaining_r  <= ADDR_ZERO;
            trig_addr_r  <= ADDR_ZERO;
            prev_r       <= {DATA_WIDTH{1'b0}};
            prev_valid_r <= 1'b0;
        end else if (arm_take_s) begin
            pre_r        <= pre_count;
            fill_r       <= ADDR_ZERO;
            prev_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                prev_r       <= bus.s_data;
                prev_valid_r <= 1'b1;
            end
            if ((state_r == PRE) && accept_s) begin
                fill_r <= fill_r + ADDR_ONE;
            end
            if (trig_s) begin
                trig_addr_r <= wptr_s;
                remaining_r <= post_len_s;
            end else if ((state_r == POST) && accept_s) begin
                remaining_r <= remaining_r - ADDR_ONE;
            end
        end
    end

    // Registered RAM write port, one cycle behind the accepting handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= ADDR_ZERO;
            wr_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_en_r <= accept_s;
            if (accept_s) begin
                wr_addr_r <= wptr_s;
                wr_data_r <= bus.s_data;
            end
        end
    end

    assign bus.s_ready = s_ready_s;
    assign bus.wr_en   = wr_en_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_r;
    assign trig_addr   = trig_addr_r;
    assign busy        = s_ready_s;
    assign done        = (state_r == DONE);

endmodule

// File: tb/tb_capture_writer.sv
// Directed self-checking bench for capture_writer with a 16-entry buffer.
module tb_capture_writer;
    import siggen_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          arm;
    logic [AW-1:0] pre_count;
    logic [DW-1:0] trig_level;
    logic [AW-1:0] trig_addr;
    logic          busy;
    logic          done;

    capture_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    capture_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .pre_count  (pre_count),
        .trig_level (trig_level),
        .bus        (bus),
        .trig_addr  (trig_addr),
        .busy       (busy),
        .done       (done)
    );

    int            n_cmp;
    int            n_err;
    int            nwr;
    int            nacc;
    logic [DW-1:0] ram [16];
    logic [AW-1:0] exp_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.wr_en === 1'b1) begin
            ram[bus.wr_addr] = bus.wr_data;
            nwr++;
        end
    endtask

    function automatic logic [DW-1:0] sample(input int pat, input int idx);
        case (pat)
            0: return DW'(idx);
            1: begin
                if (idx == 0)      return 8'd7;
                else if (idx == 1) return 8'd3;
                else if (idx == 2) return 8'd5;
                else               return DW'(idx);
            end
            2: return DW'(idx % 16);
            default: return 8'd0;
        endcase
    endfunction

    task automatic do_arm(input logic [AW-1:0] pc, input logic [DW-1:0] lvl);
        pre_count  = pc;
        trig_level = lvl;
        s_idle();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        exp_addr = 4'd0;
        nwr = 0;
        for (int a = 0; a < 16; a++) ram[a] = 8'hEE;
    endtask

    task automatic s_idle();
        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;
    endtask

    // Stream samples until done, or until stop_after accepts; optionally pulse arm.
    task automatic run(input int pat, input bit toggle, input int stop_after,
                       input int arm_at, output int n_acc);
        bit            acc;
        bit            fin;
        logic [DW-1:0] d;
        n_acc = 0;
        fin   = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            bus.s_valid = toggle ? (i % 2 == 0) : 1'b1;
            d           = sample(pat, n_acc);
            bus.s_data  = d;
            arm         = (arm_at >= 0) && (n_acc == arm_at) && bus.s_valid;
            acc         = bus.s_valid & bus.s_ready;
            tick();
            chk("wr_en", 32'(bus.wr_en), 32'(acc));
            if (acc) begin
                chk("wr_addr", 32'(bus.wr_addr), 32'(exp_addr));
                chk("wr_data", 32'(bus.wr_data), 32'(d));
                exp_addr = exp_addr + 4'd1;
                n_acc++;
            end
            if (done === 1'b1 || (stop_after > 0 && n_acc == stop_after)) fin = 1'b1;
        end
        arm = 1'b0;
        s_idle();
        if (!fin) chk("run_timeout", 32'(fin), 32'd1);
    endtask

    task automatic check_ramp_ram();
        for (int a = 0; a < 16; a++) begin
            chk($sformatf("ram%0d", a), 32'(ram[a]), (a <= 5) ? 32'(a + 16) : 32'(a));
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        nwr        = 0;
        exp_addr   = 4'd0;
        rst        = 1'b1;
        arm        = 1'b0;
        pre_count  = 4'd0;
        trig_level = 8'd0;
        s_idle();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_trig_addr", 32'(trig_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Ramp, continuous valid
        do_arm(4'd4, 8'd10);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_state", 32'(dut.state_r), 32'(PRE));
        run(0, 1'b0, 0, -1, nacc);
        chk("t1_acc", 32'(nacc), 32'd22);
        chk("t1_nwr", 32'(nwr), 32'd22);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_s_ready", 32'(bus.s_ready), 32'd0);
        chk("t1_trig_addr", 32'(trig_addr), 32'd10);
        check_ramp_ram();
        bus.s_valid = 1'b1;
        tick();
        chk("t1_hold_wr_en", 32'(bus.wr_en), 32'd0);
        chk("t1_hold_done", 32'(done), 32'd1);
        s_idle();

        // Ramp with valid toggling
        do_arm(4'd4, 8'd10);
        run(0, 1'b1, 0, -1, nacc);
        chk("t2_acc", 32'(nacc), 32'd22);
        chk("t2_nwr", 32'(nwr), 32'd22);
        chk("t2_trig_addr", 32'(trig_addr), 32'd10);
        check_ramp_ram();

        // No pre-trigger history, first sample may not trigger
        do_arm(4'd0, 8'd5);
        chk("t3_state", 32'(dut.state_r), 32'(WAIT));
        run(1, 1'b0, 0, -1, nacc);
        chk("t3_trig_addr", 32'(trig_addr), 32'd2);
        chk("t3_nwr", 32'(nwr), 32'd18);
        chk("t3_ram2", 32'(ram[2]), 32'd5);
        chk("t3_ram0", 32'(ram[0]), 32'd16);

        // Maximum pre-trigger count, POST skipped
        do_arm(4'd15, 8'd8);
        run(2, 1'b0, 0, -1, nacc);
        chk("t4_acc", 32'(nacc), 32'd25);
        chk("t4_nwr", 32'(nwr), 32'd25);
        chk("t4_trig_addr", 32'(trig_addr), 32'd8);
        chk("t4_wptr", 32'(dut.wptr_s), 32'd9);
        chk("t4_ram8", 32'(ram[8]), 32'd8);
        chk("t4_ram15", 32'(ram[15]), 32'd15);

        // arm pulsed in POST is ignored
        do_arm(4'd4, 8'd10);
        pre_count = 4'd0;
        run(0, 1'b0, 0, 13, nacc);
        chk("t5_acc", 32'(nacc), 32'd22);
        chk("t5_trig_addr", 32'(trig_addr), 32'd10);
        check_ramp_ram();

        // arm in DONE restarts in PRE
        do_arm(4'd4, 8'd10);
        chk("t5_rearm_wptr", 32'(dut.wptr_s), 32'd0);
        chk("t5_rearm_state", 32'(dut.state_r), 32'(PRE));
        chk("t5_rearm_done", 32'(done), 32'd0);

        // rst in WAIT, the cycle after an accept, with another sample offered
        run(0, 1'b0, 6, -1, nacc);
        chk("t6_state_pre", 32'(dut.state_r), 32'(WAIT));
        rst         = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'd6;
        tick();
        rst = 1'b0;
        s_idle();
        chk("t6_wr_en", 32'(bus.wr_en), 32'd0);
        chk("t6_state", 32'(dut.state_r), 32'(IDLE));
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_trig_addr", 32'(trig_addr), 32'd0);
        chk("t6_s_ready", 32'(bus.s_ready), 32'd0);
        chk("t6_wr_addr", 32'(bus.wr_addr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/capture_writer.md
Name: capture_writer

Overview:
Write-side controller for the waveform capture RAM. It accepts a sample stream over a valid/ready handshake and writes it into a circular dual-port RAM. It holds a programmable number of pre-trigger samples, detects a rising level crossing, and fills the remainder of the buffer with post-trigger samples. The read side (address counter plus RAM read port) later replays the buffer, starting from trig_addr minus pre_count.

Parameters:
ADDR_WIDTH, 8, RAM address width; DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 8, sample width (unsigned)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
arm  input  1  start/restart a capture; sampled per cycle
pre_count  input  ADDR_WIDTH  pre-trigger sample count; latched on accepted arm
trig_level  input  DATA_WIDTH  trigger threshold; used live
s_valid  input  1  input sample valid
s_data  input  DATA_WIDTH  input sample
s_ready  output  1  writer can accept a sample
wr_en  output  1  RAM write strobe (registered)
wr_addr  output  ADDR_WIDTH  RAM write address (registered)
wr_data  output  DATA_WIDTH  RAM write data (registered)
trig_addr  output  ADDR_WIDTH  RAM address of the triggering sample
busy  output  1  high in PRE, WAIT, POST
done  output  1  high in DONE

Behaviour:
- Reset: state IDLE; wptr=0; s_ready=0; wr_en=0; wr_addr=0; wr_data=0; trig_addr=0; busy=0; done=0; prev_valid=0.
- Accept = s_valid & s_ready. s_ready is combinational from state: 1 in PRE/WAIT/POST, 0 in IDLE/DONE.
- Write latency is 1 cycle:
  - On an accept in cycle N, wr_en=1 in cycle N+1, with wr_addr=wptr(N) and wr_data=s_data(N).
  - wptr then increments mod DEPTH; it wraps from DEPTH-1 to 0.
  - wr_en=0 in every other cycle.
- States: IDLE, PRE, WAIT, POST, DONE.
- arm is honoured only in IDLE or DONE; it is ignored in PRE/WAIT/POST. An honoured arm:
  - latches pre_count;
  - clears wptr, fill counter and prev_valid;
  - clears done;
  - moves to PRE, or directly to WAIT if pre_count=0.
- PRE:
  - Each accept increments the fill counter.
  - On the accept that makes fill == pre_count, go to WAIT.
- WAIT:
  - Every accepted sample is written; the buffer keeps wrapping.
  - Trigger fires on an accepted sample when prev_valid & (prev < trig_level) & (s_data >= trig_level), unsigned compare.
  - prev is the last accepted sample in any active state. prev_valid is set by the first accept after arm, so the first sample after arm can never trigger.
  - On trigger: trig_addr <= wptr (the triggering sample's address), and the sample is written.
  - remaining = DEPTH - pre_count - 1. If remaining == 0, go to DONE; else go to POST.
- POST:
  - Each accept writes the sample and decrements remaining.
  - The accept that takes remaining to 0 moves to DONE.
  - Total samples from the trigger onward = DEPTH - pre_count.
- DONE: s_ready=0 and no writes; hold until an honoured arm or rst.
- Boundary cases:
  - s_valid low for any number of cycles: state and pointers hold, no write.
  - pre_count = DEPTH-1: POST is skipped.
  - Trigger sample equal to trig_level counts as a crossing.
  - A trigger condition in PRE is ignored; only prev is updated.
- rst mid-capture: takes effect on the next edge. Any pending write is dropped (wr_en=0 the following cycle) and all outputs return to reset values.
- Counter widths: fill and remaining are ADDR_WIDTH bits. All arithmetic is mod DEPTH with no overflow flag.

Decomposition:
- Package siggen_pkg holds:
  - the capture_state_t enum (IDLE, PRE, WAIT, POST, DONE);
  - a function computing post-trigger length from ADDR_WIDTH and pre_count.
- One sub-module, addr_counter: an ADDR_WIDTH wrap-around counter with clear and enable, used for wptr.
- Fill and remaining counters stay inline.

Test Plan:
- ADDR_WIDTH=4, pre_count=4, trig_level=10, ramp input 0,1,2,… with s_valid always high:
  - samples 0-3 are written to addr 0-3;
  - trigger on sample 10, trig_addr=10;
  - 11 post writes to addr 11..15 then 0..5;
  - done=1 the cycle after sample 21 is accepted, s_ready=0 after that.
- Same setup with s_valid toggling 1,0,1,0: identical RAM contents and trig_addr. wr_en pulses only the cycle after each accept.
- pre_count=0, trig_level=5, input 7,3,5: no trigger on 7 (first sample); trigger on 5 at addr 2, trig_addr=2.
- pre_count=15 (DEPTH-1), trig_level=8, input 0..15 repeating: trigger on 8 at addr 8; done next state, no POST writes; wptr=9.
- Pulse arm during POST: ignored, counts unaffected. Pulse arm in DONE: wptr=0 and a new capture starts in PRE.
- Assert rst during WAIT, one cycle after an accept: wr_en=0 the next cycle, state IDLE, busy=0, trig_addr=0, s_ready=0.
